// File: rtl/mpu_controller_if.sv
// -----------------------------------------------------------------------------
// mpu_pkg / mpu_controller_if
//
// mpu_pkg holds the command encoding shared by the controller and its users.
//
// mpu_controller_if bundles every command, dispatch and status signal of the
// MPU controller. clk and rst stay as plain ports on the controller.
//   Command channel : op_valid, op_ready, op, op_addr, op_m_size, op_n_size
//   Load engine     : load_en, load_addr, load_m_size, load_n_size,
//                     load_ack, load_error
//   Store engine    : store_en, store_addr, store_complete
//   Status          : busy, done, error
// Modports:
//   slave  - the controller itself (accepts commands, drives dispatch/status)
//   master - the surrounding system (issues commands, answers dispatches)
// -----------------------------------------------------------------------------
package mpu_pkg;
   typedef enum logic [1:0] {
      NOP   = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } mpu_operation_t;
endpackage

interface mpu_controller_if
   import mpu_pkg::*;
#(
   parameter int MBITS           = 2,
   parameter int NBITS           = 2,
   parameter int MATRIX_REG_SIZE = 2
);
   logic                       op_valid;
   logic                       op_ready;
   mpu_operation_t             op;
   logic [MATRIX_REG_SIZE-1:0] op_addr;
   logic [MBITS:0]             op_m_size;
   logic [NBITS:0]             op_n_size;

   logic                       load_en;
   logic [MATRIX_REG_SIZE-1:0] load_addr;
   logic [MBITS:0]             load_m_size;
   logic [NBITS:0]             load_n_size;
   logic                       load_ack;
   logic                       load_error;

   logic                       store_en;
   logic [MATRIX_REG_SIZE-1:0] store_addr;
   logic                       store_complete;

   logic                       busy;
   logic                       done;
   logic                       error;

   modport slave (
      input  op_valid, op, op_addr, op_m_size, op_n_size,
             load_ack, load_error, store_complete,
      output op_ready, load_en, load_addr, load_m_size, load_n_size,
             store_en, store_addr, busy, done, error
   );

   modport master (
      output op_valid, op, op_addr, op_m_size, op_n_size,
             load_ack, load_error, store_complete,
      input  op_ready, load_en, load_addr, load_m_size, load_n_size,
             store_en, store_addr, busy, done, error
   );
endinterface

// File: rtl/mpu_controller.sv
// -----------------------------------------------------------------------------
// mpu_controller
//
// Sequences NOP / LOAD / STORE commands for a small matrix processing unit.
// A command is accepted in IDLE, its fields are captured, and it is either
// completed immediately (NOP), rejected (bad opcode, bad size, store of a
// register that was never loaded) or dispatched to the load or store engine.
// A watchdog bounds every dispatch. A per-register valid bit records which
// matrix registers hold successfully loaded data.
//
// Ports:
//   clk  - single clock, all logic on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - mpu_controller_if.slave (command, load, store and status signals)
// -----------------------------------------------------------------------------
module mpu_controller
   import mpu_pkg::*;
#(
   parameter int M               = 4,
   parameter int N               = 4,
   parameter int MBITS           = 2,
   parameter int NBITS           = 2,
   parameter int MATRIX_REG_SIZE = 2,
   parameter int TIMEOUT         = 64
) (
   input  logic               clk,
   input  logic               rst,
   mpu_controller_if.slave    bus
);

   localparam int NREGS = 2 ** MATRIX_REG_SIZE;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_RUN  = 3'd1,
      STORE_RUN = 3'd2,
      FINISH    = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t                     state;
   state_t                     state_nxt;

   // Command fields captured at acceptance, held until the next acceptance.
   mpu_operation_t             op_p0;
   logic [MATRIX_REG_SIZE-1:0] addr_p0;
   logic [MBITS:0]             m_p0;
   logic [NBITS:0]             n_p0;

   logic [NREGS-1:0]           valid_q;
   logic [WD_W-1:0]            wd;
   logic                       wd_expired;
   logic                       accept;

   // A matrix must be non-empty and fit inside the M x N register.
   function automatic logic size_ok(input logic [MBITS:0] m,
                                    input logic [NBITS:0] n);
      return (m != '0) && (n != '0) && (int'(m) <= M) && (int'(n) <= N);
   endfunction

   assign accept     = (state == IDLE) && bus.op_valid;
   assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

   // ---- state register ------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next-state logic ----------------------------------------------------
   // Rejections are decided directly from the live command inputs so that the
   // error pulse lands on the cycle right after acceptance.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.op_valid) begin
               case (bus.op)
                  NOP:   state_nxt = FINISH;
                  LOAD:  state_nxt = size_ok(bus.op_m_size, bus.op_n_size)
                                     ? LOAD_RUN : FAIL;
                  STORE: state_nxt = (size_ok(bus.op_m_size, bus.op_n_size) &&
                                      valid_q[bus.op_addr])
                                     ? STORE_RUN : FAIL;
                  default: state_nxt = FAIL;
               endcase
            end
         end
         LOAD_RUN: begin
            // A reported fault wins over a simultaneous acknowledge, and an
            // acknowledge on the last watchdog cycle still counts.
            if (bus.load_error) begin
               state_nxt = FAIL;
            end else if (bus.load_ack) begin
               state_nxt = FINISH;
            end else if (wd_expired) begin
               state_nxt = FAIL;
            end
         end
         STORE_RUN: begin
            if (bus.store_complete) begin
               state_nxt = FINISH;
            end else if (wd_expired) begin
               state_nxt = FAIL;
            end
         end
         FINISH:  state_nxt = IDLE;
         FAIL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- output logic --------------------------------------------------------
   always_comb begin
      bus.op_ready = 1'b0;
      bus.busy     = 1'b1;
      bus.load_en  = 1'b0;
      bus.store_en = 1'b0;
      bus.done     = 1'b0;
      bus.error    = 1'b0;
      case (state)
         IDLE: begin
            bus.op_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         LOAD_RUN:  bus.load_en  = 1'b1;
         STORE_RUN: bus.store_en = 1'b1;
         FINISH:    bus.done     = 1'b1;
         FAIL: begin
            bus.done  = 1'b1;
            bus.error = 1'b1;
         end
         default: begin
            bus.op_ready = 1'b0;
         end
      endcase
   end

   assign bus.load_addr   = addr_p0;
   assign bus.load_m_size = m_p0;
   assign bus.load_n_size = n_p0;
   assign bus.store_addr  = addr_p0;

   // ---- command capture, watchdog and register valid bits -------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_p0   <= NOP;
         addr_p0 <= '0;
         m_p0    <= '0;
         n_p0    <= '0;
         valid_q <= '0;
         wd      <= '0;
      end else begin
         if (accept) begin
            op_p0   <= bus.op;
            addr_p0 <= bus.op_addr;
            m_p0    <= bus.op_m_size;
            n_p0    <= bus.op_n_size;
            wd      <= '0;
         end else if (state == LOAD_RUN || state == STORE_RUN) begin
            wd <= wd + 1'b1;
         end

         if (state == LOAD_RUN && op_p0 == LOAD) begin
            if (bus.load_error) begin
               valid_q[addr_p0] <= 1'b0;
            end else if (bus.load_ack) begin
               valid_q[addr_p0] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mpu_controller.sv
// -----------------------------------------------------------------------------
// tb_mpu_controller
//
// Drives directed and random commands into mpu_controller. For each command
// the bench predicts the whole response timeline (reject / complete / run
// length / timeout) from the command, the ack delay it chose and a model of
// which registers hold loaded data. One negedge process compares every
// output against those predictions each cycle; directed cases also pin the
// prediction with hand-computed counts.
// -----------------------------------------------------------------------------
module tb_mpu_controller;
   import mpu_pkg::*;

   localparam int M       = 4;
   localparam int N       = 4;
   localparam int MBITS   = 2;
   localparam int NBITS   = 2;
   localparam int MRS     = 2;
   localparam int TIMEOUT = 64;
   localparam int NREGS   = 2 ** MRS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mpu_controller_if #(.MBITS(MBITS), .NBITS(NBITS), .MATRIX_REG_SIZE(MRS)) bus ();

   mpu_controller #(
      .M(M), .N(N), .MBITS(MBITS), .NBITS(NBITS),
      .MATRIX_REG_SIZE(MRS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   // expected outputs for the current cycle
   logic e_ready = 1'b1, e_busy = 1'b0, e_load_en = 1'b0, e_store_en = 1'b0;
   logic e_done = 1'b0, e_error = 1'b0;
   int   last_addr = 0, last_m = 0, last_n = 0;
   bit   mv [NREGS];

   // per-transaction observations
   int mon_off = 0, mon_load = 0, mon_store = 0, mon_done = 0, mon_err = 0;
   int mon_done_off = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_exp(input bit rdy, input bit bsy, input bit len, input bit sen,
                          input bit dn, input bit er);
      e_ready = rdy; e_busy = bsy; e_load_en = len; e_store_en = sen;
      e_done = dn; e_error = er;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) mv[i] = 1'b0;
      last_addr = 0; last_m = 0; last_n = 0;
      set_exp(1, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_off = 0; mon_load = 0; mon_store = 0; mon_done = 0; mon_err = 0;
      mon_done_off = -1;
   endtask

   // Randomise the command inputs while the controller is not ready.
   task automatic garbage_cmd();
      logic [1:0] g;
      g = 2'($urandom);
      bus.op_valid  = 1'($urandom);
      bus.op        = mpu_operation_t'(g);
      bus.op_addr   = MRS'($urandom);
      bus.op_m_size = (MBITS + 1)'($urandom);
      bus.op_n_size = (NBITS + 1)'($urandom);
   endtask

   // ---- compare process -----------------------------------------------------
   always @(negedge clk) begin
      chk("op_ready", bus.op_ready, e_ready);
      chk("busy",     bus.busy,     e_busy);
      chk("load_en",  bus.load_en,  e_load_en);
      chk("store_en", bus.store_en, e_store_en);
      chk("done",     bus.done,     e_done);
      chk("error",    bus.error,    e_error);
      if (e_load_en || !rst) begin
         chk("load_addr",   bus.load_addr,   last_addr);
         chk("load_m_size", bus.load_m_size, last_m);
         chk("load_n_size", bus.load_n_size, last_n);
      end
      if (e_store_en || !rst) begin
         chk("store_addr", bus.store_addr, last_addr);
      end
      if (bus.load_en)  mon_load++;
      if (bus.store_en) mon_store++;
      if (bus.error)    mon_err++;
      if (bus.done) begin
         mon_done++;
         mon_done_off = mon_off;
      end
      mon_off++;
   end

   // One command from acceptance to the end of its idle gap.
   //   op: 0 NOP, 1 LOAD, 2 STORE, 3 illegal
   //   d : run cycle on which the engine answers (0 or >TIMEOUT: never)
   //   abort_at: run cycle on which reset is asserted (0: none)
   task automatic run_txn(input int op, input int addr, input int m, input int n,
                          input int d, input bit err, input int abort_at);
      bit is_mem, bad, tmo, fail;
      int r, gap;
      is_mem = (op == 1) || (op == 2);
      bad = (op > 2) ||
            (is_mem && (m == 0 || n == 0 || m > M || n > N)) ||
            (op == 2 && !mv[addr]);
      mon_clear();

      // acceptance cycle; engine answers here must be ignored
      bus.op_valid       = 1'b1;
      bus.op             = mpu_operation_t'(2'(op));
      bus.op_addr        = MRS'(addr);
      bus.op_m_size      = (MBITS + 1)'(m);
      bus.op_n_size      = (NBITS + 1)'(n);
      bus.load_ack       = 1'($urandom);
      bus.load_error     = 1'($urandom);
      bus.store_complete = 1'($urandom);
      set_exp(1, 0, 0, 0, 0, 0);
      step();
      last_addr = addr; last_m = m; last_n = n;
      bus.load_ack = 1'b0; bus.load_error = 1'b0; bus.store_complete = 1'b0;

      if (op == 0 || bad) begin
         garbage_cmd();
         set_exp(0, 1, 0, 0, 1, bad);
         step();
      end else begin
         tmo = (d < 1) || (d > TIMEOUT);
         r   = tmo ? TIMEOUT : d;
         for (int i = 1; i <= r; i++) begin
            if (i == abort_at) begin
               rst = 1'b0;
               model_reset();
               bus.op_valid = 1'b0;
               #1;
               chk("abort_store_en", bus.store_en, 0);
               chk("abort_load_en",  bus.load_en,  0);
               chk("abort_busy",     bus.busy,     0);
               chk("abort_ready",    bus.op_ready, 1);
               step();
               step();
               rst = 1'b1;
               return;
            end
            garbage_cmd();
            set_exp(0, 1, op == 1, op == 2, 0, 0);
            if (i == d) begin
               if (op == 1) begin
                  bus.load_ack   = 1'b1;
                  bus.load_error = err;
               end else begin
                  bus.store_complete = 1'b1;
               end
            end
            step();
            bus.load_ack = 1'b0; bus.load_error = 1'b0; bus.store_complete = 1'b0;
         end
         fail = tmo || (op == 1 && err);
         garbage_cmd();
         set_exp(0, 1, 0, 0, 1, fail);
         step();
         if (op == 1 && !tmo) mv[addr] = !err;
      end

      // idle gap with stray engine answers
      bus.op_valid = 1'b0;
      set_exp(1, 0, 0, 0, 0, 0);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
         bus.load_ack       = 1'($urandom);
         bus.load_error     = 1'($urandom);
         bus.store_complete = 1'($urandom);
         step();
      end
      bus.load_ack = 1'b0; bus.load_error = 1'b0; bus.store_complete = 1'b0;
   endtask

   initial begin
      int op, addr, m, n, d, ab, k;
      bit err;
      bus.op_valid = 1'b0; bus.op = NOP; bus.op_addr = '0;
      bus.op_m_size = '0; bus.op_n_size = '0;
      bus.load_ack = 1'b0; bus.load_error = 1'b0; bus.store_complete = 1'b0;
      model_reset();

      rst = 1'b0;
      step(); step(); step();
      chk("rst_ready", bus.op_ready, 1);
      chk("rst_busy",  bus.busy,     0);
      chk("rst_done",  bus.done,     0);
      chk("rst_addr",  bus.load_addr, 0);
      rst = 1'b1;
      step();

      // store of a never-loaded register
      run_txn(2, 1, 2, 2, 3, 0, 0);
      chk("st_unloaded_err",   mon_err,      1);
      chk("st_unloaded_off",   mon_done_off, 1);
      chk("st_unloaded_sten",  mon_store,    0);

      // 2x2 load, ack on the third load_en cycle
      run_txn(1, 0, 2, 2, 3, 0, 0);
      chk("ld_len_cycles", mon_load,     3);
      chk("ld_done_off",   mon_done_off, 4);
      chk("ld_err",        mon_err,      0);
      run_txn(2, 0, 2, 2, 2, 0, 0);
      chk("st_after_ld_err", mon_err, 0);

      // load then 4-cycle store of register 1
      run_txn(1, 1, 4, 4, 1, 0, 0);
      run_txn(2, 1, 3, 1, 4, 0, 0);
      chk("st_cycles",  mon_store, 4);
      chk("st_done",    mon_done,  1);
      chk("st_err",     mon_err,   0);

      // oversize load, then a faulting load clears the valid bit
      run_txn(1, 2, 5, 2, 2, 0, 0);
      chk("ld_oversize_err",  mon_err,  1);
      chk("ld_oversize_len",  mon_load, 0);
      run_txn(1, 1, 2, 2, 2, 1, 0);
      chk("ld_fault_err", mon_err, 1);
      run_txn(2, 1, 2, 2, 2, 0, 0);
      chk("st_cleared_err", mon_err, 1);

      // watchdog
      run_txn(1, 2, 1, 1, 0, 0, 0);
      chk("tmo_err",     mon_err,      1);
      chk("tmo_off",     mon_done_off, TIMEOUT + 1);
      chk("tmo_len",     mon_load,     TIMEOUT);
      chk("tmo_ready",   bus.op_ready, 1);

      // NOP and illegal opcode
      run_txn(0, 3, 0, 0, 0, 0, 0);
      chk("nop_off", mon_done_off, 1);
      chk("nop_err", mon_err,      0);
      run_txn(3, 0, 1, 1, 1, 0, 0);
      chk("badop_err", mon_err, 1);

      // reset during a store run
      run_txn(1, 3, 2, 2, 1, 0, 0);
      run_txn(2, 3, 2, 2, 10, 0, 3);
      chk("abort_no_done", mon_done, 0);
      run_txn(2, 3, 2, 2, 2, 0, 0);
      chk("st_after_abort_err", mon_err, 1);

      // random traffic
      for (int t = 0; t < 300; t++) begin
         k = $urandom_range(0, 9);
         op = (k == 0) ? 0 : (k == 1) ? 3 : (k < 6) ? 1 : 2;
         addr = $urandom_range(0, NREGS - 1);
         m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, M);
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, N);
         d = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, 6);
         err = ($urandom_range(0, 3) == 0);
         ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 0;
         run_txn(op, addr, m, n, d, err, ab);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
